// File: rtl/ahb_lite_mp_ram_slave.sv
// N independent AHB-Lite slave ports sharing one single-port word RAM through a
// round-robin arbiter; illegal transfers get a two-cycle ERROR without arbitration.

module ahb_mp_ram_port #(
  parameter int                   ADDRWIDTH = 32,
  parameter int                   DATAWIDTH = 32,
  parameter int                   MEM_DEPTH = 1024,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = '0,
  parameter int                   IW        = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hsel,
  input  logic [ADDRWIDTH-1:0]   haddr,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  input  logic                   gnt,
  input  logic [DATAWIDTH-1:0]   rd_word,
  output logic                   req,
  output logic                   wr,
  output logic [IW-1:0]          idx,
  output logic [DATAWIDTH/8-1:0] be,
  output logic [DATAWIDTH-1:0]   hrdata,
  output logic                   hreadyout,
  output logic                   hresp
);
  localparam int          NB        = DATAWIDTH / 8;
  localparam int          LOG2NB    = $clog2(NB);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NB);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ERR1, S_ERR2} state_t;
  state_t state, state_nxt;

  logic [ADDRWIDTH-1:0] off, amask;
  logic [IW-1:0]        idx_nxt;
  logic [NB-1:0]        be_nxt;
  logic [DATAWIDTH-1:0] rdata_q;
  logic                 active, err, accept;

  always_comb begin
    active  = hsel && hready && (htrans == 2'b10 || htrans == 2'b11);
    off     = haddr - BASE_ADDR;
    amask   = (ADDRWIDTH'(1) << hsize) - ADDRWIDTH'(1);
    err     = (haddr < BASE_ADDR) || (64'(off) >= MEM_BYTES) ||
              (int'(hsize) > LOG2NB) || ((off & amask) != '0);
    idx_nxt = IW'(off >> LOG2NB);
    // A lane is enabled when it sits in the same 2^hsize block as the address.
    be_nxt  = '0;
    for (int b = 0; b < NB; b++)
      be_nxt[b] = ((b ^ int'(off[LOG2NB-1:0])) >> hsize) == 0;
  end

  // New transfers are only taken when the previous data phase completes now.
  assign accept = active && (state == S_IDLE || (state == S_PEND && gnt));
  assign req    = (state == S_PEND);

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = err ? S_ERR1 : S_PEND;
      S_PEND: begin
        hreadyout = gnt;
        if (accept)   state_nxt = err ? S_ERR1 : S_PEND;
        else if (gnt) state_nxt = S_IDLE;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        hresp     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      be      <= '0;
      wr      <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !err) begin
        idx <= idx_nxt;
        be  <= be_nxt;
        wr  <= hwrite;
      end
      if (gnt && !wr) rdata_q <= rd_word;
    end
  end

  assign hrdata = (gnt && !wr) ? rd_word : rdata_q;
endmodule

module ahb_lite_mp_ram_slave #(
  parameter int                   NUM_PORTS = 2,
  parameter int                   ADDRWIDTH = 32,
  parameter int                   DATAWIDTH = 32,
  parameter int                   MEM_DEPTH = 1024,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_PORTS-1:0]           HSEL,
  input  logic [NUM_PORTS*ADDRWIDTH-1:0] HADDR,
  input  logic [NUM_PORTS-1:0]           HWRITE,
  input  logic [NUM_PORTS*3-1:0]         HSIZE,
  input  logic [NUM_PORTS*2-1:0]         HTRANS,
  input  logic [NUM_PORTS*DATAWIDTH-1:0] HWDATA,
  input  logic [NUM_PORTS-1:0]           HREADY,
  output logic [NUM_PORTS*DATAWIDTH-1:0] HRDATA,
  output logic [NUM_PORTS-1:0]           HREADYOUT,
  output logic [NUM_PORTS-1:0]           HRESP
);
  localparam int NB = DATAWIDTH / 8;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]         req, gnt, wr;
  logic [NUM_PORTS-1:0][IW-1:0] idx;
  logic [NUM_PORTS-1:0][NB-1:0] be;
  logic [PW-1:0]                last_grant, gnt_id;
  logic                         any_gnt;
  logic [DATAWIDTH-1:0]         rd_word, wdata_sel;
  logic [DATAWIDTH-1:0]         mem [MEM_DEPTH];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ahb_mp_ram_port #(
      .ADDRWIDTH(ADDRWIDTH), .DATAWIDTH(DATAWIDTH), .MEM_DEPTH(MEM_DEPTH),
      .BASE_ADDR(BASE_ADDR), .IW(IW)
    ) u_port (
      .clk      (HCLK),
      .rst      (HRESET),
      .hsel     (HSEL[p]),
      .haddr    (HADDR[p*ADDRWIDTH +: ADDRWIDTH]),
      .hwrite   (HWRITE[p]),
      .hsize    (HSIZE[p*3 +: 3]),
      .htrans   (HTRANS[p*2 +: 2]),
      .hready   (HREADY[p]),
      .gnt      (gnt[p]),
      .rd_word  (rd_word),
      .req      (req[p]),
      .wr       (wr[p]),
      .idx      (idx[p]),
      .be       (be[p]),
      .hrdata   (HRDATA[p*DATAWIDTH +: DATAWIDTH]),
      .hreadyout(HREADYOUT[p]),
      .hresp    (HRESP[p])
    );
  end

  // Round-robin: search starts one past the last granted port.
  always_comb begin : arb
    int p;
    gnt     = '0;
    gnt_id  = last_grant;
    any_gnt = 1'b0;
    p       = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      p = (int'(last_grant) + i) % NUM_PORTS;
      if (!any_gnt && req[p]) begin
        any_gnt = 1'b1;
        gnt[p]  = 1'b1;
        gnt_id  = PW'(p);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)       last_grant <= '0;
    else if (any_gnt) last_grant <= gnt_id;
  end

  assign rd_word   = mem[idx[gnt_id]];
  assign wdata_sel = HWDATA[int'(gnt_id)*DATAWIDTH +: DATAWIDTH];

  // Reset clears every port to IDLE asynchronously, so no grant (and no write) exists under reset.
  always_ff @(posedge HCLK) begin
    if (any_gnt && wr[gnt_id])
      for (int b = 0; b < NB; b++)
        if (be[gnt_id][b]) mem[idx[gnt_id]][b*8 +: 8] <= wdata_sel[b*8 +: 8];
  end
endmodule
